// File: rtl/bsg_split3_rr.sv
// Registered 1-to-3 splitter: one valid/ready input stream is dealt round-robin
// into three single-entry output lanes (a, b, c), each drained by valid/yumi.
module bsg_split3_rr #(
   parameter int width_p = 64
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_o,
   output logic [2:0]         v_o,
   output logic [width_p-1:0] data_a_o,
   output logic [width_p-1:0] data_b_o,
   output logic [width_p-1:0] data_c_o,
   input  logic [2:0]         yumi_i
);

   logic [2:0]         full_q, full_d;
   logic [1:0]         ptr_q, ptr_d;
   logic [1:0]         ptr_eff;
   logic [1:0]         sel;
   logic [2:0]         free;
   logic               accept;
   logic [width_p-1:0] data_a_q, data_b_q, data_c_q;

   // A lane being drained this cycle counts as free so it can be refilled at once.
   assign free    = ~full_q | yumi_i;
   assign ready_o = |free;
   assign accept  = v_i & ready_o;
   assign ptr_eff = (ptr_q == 2'd3) ? 2'd0 : ptr_q;

   always_comb begin
      sel = 2'd0;
      case (ptr_eff)
         2'd1: begin
            if (free[1])      sel = 2'd1;
            else if (free[2]) sel = 2'd2;
            else              sel = 2'd0;
         end
         2'd2: begin
            if (free[2])      sel = 2'd2;
            else if (free[0]) sel = 2'd0;
            else              sel = 2'd1;
         end
         default: begin
            if (free[0])      sel = 2'd0;
            else if (free[1]) sel = 2'd1;
            else              sel = 2'd2;
         end
      endcase
   end

   always_comb begin
      full_d = full_q & ~yumi_i;
      ptr_d  = ptr_eff;
      if (accept) begin
         full_d[sel] = 1'b1;
         ptr_d       = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         full_q   <= 3'b000;
         ptr_q    <= 2'd0;
         data_a_q <= '0;
         data_b_q <= '0;
         data_c_q <= '0;
      end else begin
         full_q <= full_d;
         ptr_q  <= ptr_d;
         if (accept && sel == 2'd0) data_a_q <= data_i;
         if (accept && sel == 2'd1) data_b_q <= data_i;
         if (accept && sel == 2'd2) data_c_q <= data_i;
      end
   end

   assign v_o      = full_q;
   assign data_a_o = data_a_q;
   assign data_b_o = data_b_q;
   assign data_c_o = data_c_q;

   // Consuming an empty lane is a consumer bug; the logic ignores it.
   assert property (@(posedge clk_i) disable iff (reset_i) (yumi_i & ~full_q) == 3'b000)
      else $warning("bsg_split3_rr: yumi_i on empty lane ignored");

endmodule

// File: tb/tb_bsg_split3_rr.sv
// Bench for bsg_split3_rr: directed scenarios plus random traffic, compared
// against a lane-level reference model and per-lane expected-word queues.
module tb_bsg_split3_rr;
  localparam int W = 64;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         v_i;
  logic [W-1:0] data_i;
  logic         ready_o;
  logic [2:0]   v_o;
  logic [W-1:0] data_a_o, data_b_o, data_c_o;
  logic [2:0]   yumi_i;

  bsg_split3_rr #(.width_p(W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
    .ready_o(ready_o), .v_o(v_o), .data_a_o(data_a_o), .data_b_o(data_b_o),
    .data_c_o(data_c_o), .yumi_i(yumi_i)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int n_accept = 0;

  // reference model
  logic [2:0]   m_full;
  logic [W-1:0] m_data [3];
  int           m_ptr;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] lane_out(input int k);
    case (k)
      0: return data_a_o;
      1: return data_b_o;
      default: return data_c_o;
    endcase
  endfunction

  task automatic model_reset();
    m_full = 3'b000;
    for (int k = 0; k < 3; k++) m_data[k] = '0;
    m_ptr = 0;
    exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".v_o"}, W'(v_o), W'(m_full));
    check({tag, ".data_a"}, data_a_o, m_data[0]);
    check({tag, ".data_b"}, data_b_o, m_data[1]);
    check({tag, ".data_c"}, data_c_o, m_data[2]);
  endtask

  // driver: one cycle of stimulus, called at posedge+1
  task automatic step(input logic v, input logic [W-1:0] d, input logic [2:0] y);
    logic [2:0]   fr;
    int           sel;
    logic         acc;
    logic [W-1:0] e;
    v_i = v; data_i = d; yumi_i = y;
    #1;
    fr = ~m_full | y;
    check("ready_o", W'(ready_o), W'(|fr));
    sel = -1;
    for (int i = 0; i < 3; i++)
      if (sel < 0 && fr[(m_ptr + i) % 3]) sel = (m_ptr + i) % 3;
    acc = v && (sel >= 0);
    for (int k = 0; k < 3; k++) begin
      if (y[k] && m_full[k]) begin
        if (k == 0) e = exp_q0.pop_front();
        else if (k == 1) e = exp_q1.pop_front();
        else e = exp_q2.pop_front();
        check("yumi_word", lane_out(k), e);
      end
    end
    @(posedge clk_i);
    #1;
    m_full = m_full & ~y;
    if (acc) begin
      m_full[sel] = 1'b1;
      m_data[sel] = d;
      m_ptr = (sel + 1) % 3;
      if (sel == 0) exp_q0.push_back(d);
      else if (sel == 1) exp_q1.push_back(d);
      else exp_q2.push_back(d);
      n_accept++;
    end
    check_outputs("step");
  endtask

  task automatic do_reset();
    v_i = 1'b0; yumi_i = 3'b000; data_i = '0;
    reset_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_i = 1'b1; v_i = 1'b0; yumi_i = 3'b000; data_i = '0;
    do_reset();
    check_outputs("reset");
    check("reset.ready_o", W'(ready_o), W'(1));

    // round-robin fill, then all-full stalls
    step(1'b1, W'(64'h11), 3'b000);
    step(1'b1, W'(64'h22), 3'b000);
    step(1'b1, W'(64'h33), 3'b000);
    check("fill.a", data_a_o, W'(64'h11));
    check("fill.b", data_b_o, W'(64'h22));
    check("fill.c", data_c_o, W'(64'h33));
    check("fill.v", W'(v_o), W'(3'b111));
    step(1'b1, W'(64'hdead), 3'b000);
    check("full.stall_v", W'(v_o), W'(3'b111));

    // skip occupied lane: drain b only, ptr still at a
    step(1'b0, '0, 3'b010);
    step(1'b1, W'(64'h44), 3'b000);
    check("skip.b", data_b_o, W'(64'h44));
    step(1'b1, W'(64'h45), 3'b001);
    check("skip.a", data_a_o, W'(64'h45));

    // same-cycle drain and refill of b (all full, ptr=1)
    step(1'b1, W'(64'h55), 3'b010);
    check("refill.b", data_b_o, W'(64'h55));
    check("refill.v", W'(v_o), W'(3'b111));
    step(1'b1, W'(64'h56), 3'b100);
    check("refill.c_ptr2", data_c_o, W'(64'h56));

    // asynchronous reset between edges
    @(negedge clk_i);
    v_i = 1'b0; yumi_i = 3'b000;
    #2;
    reset_i = 1'b1;
    #1;
    model_reset();
    check("async_rst.v_o", W'(v_o), W'(0));
    check("async_rst.a", data_a_o, '0);
    check("async_rst.b", data_b_o, '0);
    check("async_rst.c", data_c_o, '0);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    step(1'b1, W'(64'h77), 3'b000);
    check("async_rst.ptr_a", data_a_o, W'(64'h77));

    // illegal yumi on empty lanes is ignored
    do_reset();
    step(1'b0, '0, 3'b100);
    check("illegal.v_o", W'(v_o), W'(0));
    step(1'b1, W'(64'h88), 3'b000);
    check("illegal.ptr_a", data_a_o, W'(64'h88));

    // full throughput: 300 words in 300 cycles
    do_reset();
    n_accept = 0;
    for (int i = 0; i < 300; i++) step(1'b1, W'(i), m_full);
    check("throughput.count", W'(n_accept), W'(300));

    // random traffic
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), {$urandom, $urandom},
           3'($urandom_range(0, 7)) & m_full);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end, expected finish");
    $fatal(1);
  end
endmodule
